div_seq: RTL and testbench



---
 rtl/div_seq_pkg.sv | 27 ++
 rtl/div_seq_if.sv | 46 ++++
 rtl/div_step.sv | 32 +++
 rtl/div_seq.sv | 133 +++++++++++++
 tb/tb_div_seq.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/div_seq_pkg.sv
// div_seq_pkg
// Shared constants, FSM state type and two's-complement helpers for the
// sequential signed divider (div_seq) and its restoring step (div_step).
// Optional feature macro used by this slice: DIV_SEQ_UNSIGNED_EN.
// No ports (package).
package div_seq_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2,
    DZERO  = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  // |-2^31| stays 0x80000000 because the result is read as unsigned.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? negate(v) : v;
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// div_seq_if
// Divide handshake between the control unit (master) and the divider (slave).
// Signals:
//   div_start            master->slave  one-cycle start request
//   dividend, divisor    master->slave  operands, sampled on accepted start
//   div_unsigned         master->slave  only with DIV_SEQ_UNSIGNED_EN
//   div_busy             slave->master  division in progress
//   div_stop, div_zero   slave->master  completion / divide-by-zero pulses
//   hi_out, lo_out       slave->master  remainder / quotient
interface div_seq_if;
  import div_seq_pkg::*;

  logic             div_start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             div_busy;
  logic             div_stop;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

`ifdef DIV_SEQ_UNSIGNED_EN
  logic             div_unsigned;

  modport master (
    output div_start, dividend, divisor, div_unsigned,
    input  div_busy, div_stop, div_zero, hi_out, lo_out
  );

  modport slave (
    input  div_start, dividend, divisor, div_unsigned,
    output div_busy, div_stop, div_zero, hi_out, lo_out
  );
`else
  modport master (
    output div_start, dividend, divisor,
    input  div_busy, div_stop, div_zero, hi_out, lo_out
  );

  modport slave (
    input  div_start, dividend, divisor,
    output div_busy, div_stop, div_zero, hi_out, lo_out
  );
`endif

endinterface

// File: rtl/div_step.sv
// div_step
// One combinational restoring-division iteration on magnitudes.
// Ports:
//   rem       in   current partial remainder (always < dsr)
//   quo       in   shift register: unconsumed dividend bits on top,
//                  quotient bits collected at the bottom
//   dsr       in   divisor magnitude
//   rem_next  out  partial remainder after this step
//   quo_next  out  shift register after this step
module div_step
  import div_seq_pkg::*;
(
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // The shifted remainder needs one extra bit: in unsigned mode the divisor
  // can be up to 2^32-1, so rem*2+1 can exceed 32 bits before the compare.
  logic [WIDTH:0] shifted;
  logic           take;

  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    take     = (shifted >= {1'b0, dsr});
    rem_next = take ? (shifted[WIDTH-1:0] - dsr) : shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], take};
  end

endmodule

// File: rtl/div_seq.sv
// div_seq
// Sequential 32-bit signed restoring divider answering the control unit's
// divide handshake. 32 iteration cycles plus one sign-fix cycle; quotient on
// lo_out (truncated toward zero), remainder on hi_out (sign of dividend).
// Optional macro DIV_SEQ_UNSIGNED_EN adds div_unsigned for MIPS divu.
// Ports:
//   clk    in  clock, all state on rising edge
//   reset  in  synchronous active-high reset
//   bus    div_seq_if.slave (start/operands in, busy/stop/zero/hi/lo out)
module div_seq
  import div_seq_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  div_seq_if.slave  bus
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dsr_mag;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic             q_neg;
  logic             r_neg;
  logic             stop_q;
  logic             zero_q;
  logic             signed_op;

  logic             load;
  logic             step;
  logic             finish;
  logic             stop_next;
  logic             zero_next;

`ifdef DIV_SEQ_UNSIGNED_EN
  assign signed_op = ~bus.div_unsigned;
`else
  assign signed_op = 1'b1;
`endif

  div_step u_step (
    .rem      (rem),
    .quo      (quo),
    .dsr      (dsr_mag),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // count runs 0..31 in CALC, so the 32nd step hands over to FINISH.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.div_start) state_next = (bus.divisor == '0) ? DZERO : CALC;
      CALC:    if (count == CNT_W'(WIDTH - 1)) state_next = FINISH;
      FINISH:  state_next = IDLE;
      DZERO:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    stop_next = 1'b0;
    zero_next = 1'b0;
    case (state)
      IDLE:   load = bus.div_start && (bus.divisor != '0);
      CALC:   step = 1'b1;
      FINISH: begin
        finish    = 1'b1;
        stop_next = 1'b1;
      end
      DZERO:  begin
        stop_next = 1'b1;
        zero_next = 1'b1;
      end
      default: ;
    endcase
  end

  // The stop/zero pulses are registered, so they appear in the cycle after
  // the FINISH/DZERO edge, together with the freshly written hi/lo values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      rem     <= '0;
      quo     <= '0;
      dsr_mag <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      stop_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      stop_q <= stop_next;
      zero_q <= zero_next;
      if (load) begin
        quo     <= signed_op ? abs_val(bus.dividend) : bus.dividend;
        dsr_mag <= signed_op ? abs_val(bus.divisor)  : bus.divisor;
        q_neg   <= signed_op & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
        r_neg   <= signed_op & bus.dividend[WIDTH-1];
        rem     <= '0;
        count   <= '0;
      end else if (step) begin
        rem   <= rem_step;
        quo   <= quo_step;
        count <= count + CNT_W'(1);
      end else if (finish) begin
        lo_q <= q_neg ? negate(quo) : quo;
        hi_q <= r_neg ? negate(rem) : rem;
      end
    end
  end

  assign bus.div_busy = (state != IDLE);
  assign bus.div_stop = stop_q;
  assign bus.div_zero = zero_q;
  assign bus.lo_out   = lo_q;
  assign bus.hi_out   = hi_q;

endmodule

// File: tb/tb_div_seq.sv
`timescale 1ns/1ps
// tb_div_seq
// Self-checking bench for div_seq: table of signed vectors, random vectors
// against a signed-arithmetic model, and hand-written sequences for ignored
// restarts, reset abort and (with DIV_SEQ_UNSIGNED_EN) unsigned mode.
// Expected results go into a scoreboard queue when a start is driven and are
// popped when div_stop is seen.
module tb_div_seq;
  import div_seq_pkg::*;

  logic clk = 1'b0;
  logic reset;

  div_seq_if bus();

  div_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
  } exp_t;

  exp_t        sbq[$];
  vec_t        vecs[15];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] lastLo = '0;
  logic [31:0] lastHi = '0;

  // Generic comparison; every scored check goes through here.
  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Drives one start pulse; returns just after the accepting edge E.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic uns,
                               input logic [31:0] expLo, input logic [31:0] expHi,
                               input bit expectDone);
    exp_t e;
    if (expectDone) begin
      if (b == '0) begin
        e = '{lastLo, lastHi, 1'b1};
      end else begin
        e = '{expLo, expHi, 1'b0};
        lastLo = expLo;
        lastHi = expHi;
      end
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.div_start = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
`ifdef DIV_SEQ_UNSIGNED_EN
    bus.div_unsigned = uns;
`else
    if (uns) $display("[TB] note: unsigned request ignored in signed-only build");
`endif
    @(posedge clk);
    #1;
    bus.div_start = 1'b0;
    bus.dividend  = $urandom;
    bus.divisor   = $urandom;
    checkValue("busy_after_start", {31'd0, bus.div_busy}, 32'd1);
  endtask

  // Waits (bounded) for div_stop, expected exactly expLat edges from now.
  task automatic checkOutput(input int expLat, input string tag);
    int   n = 0;
    bit   early = 0;
    exp_t e;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!bus.div_stop && (!bus.div_busy || bus.div_zero)) early = 1;
    end while (!bus.div_stop && n < 100);
    checkValue({tag, "_stop_seen"}, {31'd0, bus.div_stop}, 32'd1);
    checkValue({tag, "_latency"}, n, expLat);
    checkValue({tag, "_busy_hold"}, {31'd0, early}, 32'd0);
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_scoreboard: got empty queue, expected one entry", tag);
    end else begin
      e = sbq.pop_front();
      checkValue({tag, "_lo"}, bus.lo_out, e.lo);
      checkValue({tag, "_hi"}, bus.hi_out, e.hi);
      checkValue({tag, "_zero"}, {31'd0, bus.div_zero}, {31'd0, e.zero});
      checkValue({tag, "_busy_at_stop"}, {31'd0, bus.div_busy}, 32'd0);
    end
    @(posedge clk);
    #1;
    checkValue({tag, "_pulse_end"}, {29'd0, bus.div_stop, bus.div_zero, bus.div_busy}, 32'd0);
  endtask

  // No completion pulse may appear for the given number of cycles.
  task automatic expectQuiet(input int cycles, input string tag);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.div_stop || bus.div_zero) seen++;
    end
    checkValue({tag, "_no_pulse"}, seen, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          sa;
    int          sd;

    bus.div_start = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
`ifdef DIV_SEQ_UNSIGNED_EN
    bus.div_unsigned = 1'b0;
`endif

    vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1]  = '{32'd5,          32'd0,          32'd0,          32'd0};
    vecs[2]  = '{32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
    vecs[3]  = '{32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1};
    vecs[4]  = '{32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF};
    vecs[5]  = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
    vecs[6]  = '{32'h80000000,   32'd1,          32'h80000000,   32'd0};
    vecs[7]  = '{32'd0,          32'd5,          32'd0,          32'd0};
    vecs[8]  = '{32'd5,          32'd100,        32'd0,          32'd5};
    vecs[9]  = '{32'h7FFFFFFF,   32'h7FFFFFFF,   32'd1,          32'd0};
    vecs[10] = '{32'd123456789,  32'd1000,       32'd123456,     32'd789};
    vecs[11] = '{32'd123456789,  32'hFFFFFC18,   32'hFFFE1DC0,   32'd789};
    vecs[12] = '{32'h80000000,   32'h80000000,   32'd1,          32'd0};
    vecs[13] = '{32'h7FFFFFFF,   32'h80000000,   32'd0,          32'h7FFFFFFF};
    vecs[14] = '{32'hFFFFFFFF,   32'd0,          32'd0,          32'd0};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkValue("reset_busy", {31'd0, bus.div_busy}, 32'd0);
    checkValue("reset_stop", {31'd0, bus.div_stop}, 32'd0);
    checkValue("reset_zero", {31'd0, bus.div_zero}, 32'd0);
    checkValue("reset_lo", bus.lo_out, 32'd0);
    checkValue("reset_hi", bus.hi_out, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, 1'b0, vecs[i].lo, vecs[i].hi, 1'b1);
      checkOutput((vecs[i].b == '0) ? 1 : 33, $sformatf("vec%0d", i));
    end

    // Random signed vectors against the language's truncating division.
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
      if (i % 4 == 1) b = -b;
      if (b == '0) b = 32'd1;
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
      sa = a;
      sd = b;
      applyStimulus(a, b, 1'b0, 32'(sa / sd), 32'(sa % sd), 1'b1);
      checkOutput(33, $sformatf("rnd%0d", i));
    end

    // A start while busy (with new operands) must be ignored entirely.
    applyStimulus(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    bus.div_start = 1'b1;
    bus.dividend  = 32'd9;
    bus.divisor   = 32'd3;
    @(posedge clk);
    #1;
    bus.div_start = 1'b0;
    checkOutput(23, "ignored_start");
    expectQuiet(40, "ignored_start");

    // Reset mid-division aborts with no completion pulse.
    applyStimulus(32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    bus.div_start = 1'b1;
    bus.dividend  = 32'd9;
    bus.divisor   = 32'd3;
    @(posedge clk);
    #1;
    bus.div_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    lastLo = '0;
    lastHi = '0;
    checkValue("abort_busy", {31'd0, bus.div_busy}, 32'd0);
    checkValue("abort_stop", {31'd0, bus.div_stop}, 32'd0);
    checkValue("abort_lo", bus.lo_out, 32'd0);
    checkValue("abort_hi", bus.hi_out, 32'd0);
    expectQuiet(40, "abort");
    applyStimulus(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b1);
    checkOutput(33, "after_abort");

`ifdef DIV_SEQ_UNSIGNED_EN
    applyStimulus(32'hFFFFFFFF, 32'd2, 1'b1, 32'h7FFFFFFF, 32'd1, 1'b1);
    checkOutput(33, "divu");
    applyStimulus(32'hFFFFFFFF, 32'd2, 1'b0, 32'd0, 32'hFFFFFFFF, 1'b1);
    checkOutput(33, "div_same_ops");
    applyStimulus(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, 32'h80000000, 1'b1);
    checkOutput(33, "divu_big");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
